// File: rtl/packet_flit_transmitter_if.sv
// Channel bundle for the packet flit transmitter.
// The master side is the environment: it offers packets and returns
// downstream credits. The slave side is the transmitter, which accepts
// packets and drives the flit channel.
interface packet_flit_transmitter_if #(
  parameter int FLIT_WIDTH   = 32,
  parameter int PACKET_FLITS = 5
) ();

  // Packet handshake: a transfer happens on the rising edge where
  // packet_valid and packet_ready are both high. The producer holds
  // packet_valid and packet_in stable until that edge.
  logic [PACKET_FLITS*FLIT_WIDTH-1:0] packet_in;
  logic                               packet_valid;
  logic                               packet_ready;

  // Flit channel: bit 0 is the flit valid, bits [FLIT_WIDTH:1] the flit.
  logic [FLIT_WIDTH:0]                channel_out;

  // One-cycle pulse per downstream buffer slot freed.
  logic                               credit_in;

  modport master (
    output packet_in,
    output packet_valid,
    output credit_in,
    input  packet_ready,
    input  channel_out
  );

  modport slave (
    input  packet_in,
    input  packet_valid,
    input  credit_in,
    output packet_ready,
    output channel_out
  );

endinterface

// File: rtl/packet_flit_transmitter.sv
// Credit-based packet injector: accepts a whole packet, then serializes it
// into flits on the channel, spending one downstream credit per flit.
module packet_flit_transmitter #(
  parameter int FLIT_WIDTH   = 32,
  parameter int PACKET_FLITS = 5,
  parameter int BUFFER_DEPTH = 5,
  parameter int CREDIT_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  packet_flit_transmitter_if.slave bus,
  output logic [CREDIT_WIDTH-1:0] credits_available,
  output logic                    busy,
  output logic                    credit_error,
  output logic [0:0]              state_o
);

  localparam int PKT_W = PACKET_FLITS * FLIT_WIDTH;
  localparam int IDX_W = (PACKET_FLITS > 1) ? $clog2(PACKET_FLITS) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam logic [CREDIT_WIDTH-1:0] MAX_CRED = CREDIT_WIDTH'(BUFFER_DEPTH);
  localparam logic [CREDIT_WIDTH-1:0] ONE_CRED = CREDIT_WIDTH'(1);
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(PACKET_FLITS - 1);
  localparam logic [IDX_W-1:0]        ONE_IDX  = IDX_W'(1);

  logic [0:0]              state_q, state_d;
  logic [PKT_W-1:0]        pkt_q, pkt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [FLIT_WIDTH:0]     chan_q, chan_d;
  logic [CREDIT_WIDTH-1:0] credits_q, credits_d;
  logic                    credit_error_q, credit_error_d;
  logic                    send;

  // A flit leaves only while sending and a downstream slot is known free.
  assign send = (state_q == SEND) && (credits_q != '0);

  // Packet FSM: latch on accept, then shift out flit 0 first (held in the MSBs).
  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    idx_d   = idx_q;
    chan_d  = {chan_q[FLIT_WIDTH:1], 1'b0};
    case (state_q)
      IDLE: begin
        if (bus.packet_valid) begin
          pkt_d   = bus.packet_in;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (send) begin
          chan_d = {pkt_q[PKT_W-1 -: FLIT_WIDTH], 1'b1};
          pkt_d  = pkt_q << FLIT_WIDTH;
          idx_d  = idx_q + ONE_IDX;
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Credit counter: a send and a returned credit on the same edge cancel;
  // a return with the counter already full saturates and flags an error.
  always_comb begin
    credits_d      = credits_q;
    credit_error_d = credit_error_q;
    if (send && !bus.credit_in) begin
      credits_d = credits_q - ONE_CRED;
    end else if (!send && bus.credit_in) begin
      if (credits_q == MAX_CRED) begin
        credit_error_d = 1'b1;
      end else begin
        credits_d = credits_q + ONE_CRED;
      end
    end
  end

  // State registers; reset abandons any packet in flight and refills credits.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      pkt_q          <= '0;
      idx_q          <= '0;
      chan_q         <= '0;
      credits_q      <= MAX_CRED;
      credit_error_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pkt_q          <= pkt_d;
      idx_q          <= idx_d;
      chan_q         <= chan_d;
      credits_q      <= credits_d;
      credit_error_q <= credit_error_d;
    end
  end

  assign bus.packet_ready  = (state_q == IDLE);
  assign bus.channel_out   = chan_q;
  assign busy              = (state_q == SEND);
  assign credits_available = credits_q;
  assign credit_error      = credit_error_q;
  assign state_o           = state_q;

endmodule

// File: tb/tb_packet_flit_transmitter.sv
// Self-checking bench for packet_flit_transmitter: directed sequences,
// a table of per-cycle vectors and randomized traffic against a
// queue-based reference model.
module tb_packet_flit_transmitter;

  localparam int FW    = 32;
  localparam int PF    = 5;
  localparam int BD    = 5;
  localparam int CW    = 3;
  localparam int PKT_W = PF * FW;

  logic          clk;
  logic          reset;
  logic [CW-1:0] credits_available;
  logic          busy;
  logic          credit_error;
  logic [0:0]    state_o;

  packet_flit_transmitter_if #(.FLIT_WIDTH(FW), .PACKET_FLITS(PF)) bus ();

  packet_flit_transmitter #(
    .FLIT_WIDTH(FW), .PACKET_FLITS(PF), .BUFFER_DEPTH(BD), .CREDIT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .credits_available(credits_available),
    .busy(busy),
    .credit_error(credit_error),
    .state_o(state_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / reference model ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [FW-1:0] exp_q[$];     // flits accepted but not yet seen on the channel
  int          m_cred = BD;     // downstream slots believed free
  logic        m_err  = 1'b0;
  logic [FW-1:0] m_flit = '0;   // last flit value put on the channel
  logic        last_acc = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [PKT_W-1:0] mk_pkt(input logic [FW-1:0] base);
    logic [PKT_W-1:0] p;
    p = '0;
    for (int i = 0; i < PF; i++) p[(PF-1-i)*FW +: FW] = base + FW'(i + 1);
    return p;
  endfunction

  // One clock: capture inputs, advance the model across the edge, compare.
  task automatic tick();
    logic rst_b, cr_b, acc_b, send_b;
    logic [PKT_W-1:0] pkt_b;
    rst_b  = reset;
    cr_b   = bus.credit_in;
    pkt_b  = bus.packet_in;
    acc_b  = bus.packet_valid && (exp_q.size() == 0);
    send_b = (exp_q.size() > 0) && (m_cred > 0);
    @(posedge clk);
    #1;
    last_acc = 1'b0;
    if (rst_b) begin
      exp_q.delete();
      m_cred = BD;
      m_err  = 1'b0;
      m_flit = '0;
      check("reset_channel", 64'(bus.channel_out), 64'd0);
    end else begin
      check("flit_valid", 64'(bus.channel_out[0]), 64'(send_b));
      if (send_b) m_flit = exp_q.pop_front();
      check("flit_data", 64'(bus.channel_out[FW:1]), 64'(m_flit));
      if (send_b) m_cred--;
      if (cr_b) begin
        if (m_cred == BD) m_err = 1'b1;
        else m_cred++;
      end
      if (acc_b) begin
        for (int i = 0; i < PF; i++) exp_q.push_back(pkt_b[(PF-1-i)*FW +: FW]);
        last_acc = 1'b1;
      end
    end
    check("credits_model", 64'(credits_available), 64'(m_cred));
    check("credit_error_model", 64'(credit_error), 64'(m_err));
    check("ready_model", 64'(bus.packet_ready), 64'(exp_q.size() == 0));
    check("busy_model", 64'(busy), 64'(exp_q.size() != 0));
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    reset = 1'b1;
    bus.packet_valid = 1'b0;
    bus.credit_in = 1'b0;
    for (int i = 0; i < n; i++) tick();
    reset = 1'b0;
  endtask

  // Offer a packet for exactly one edge (caller knows the block is idle).
  task automatic accept_pkt(input logic [PKT_W-1:0] p);
    bus.packet_in = p;
    bus.packet_valid = 1'b1;
    tick();
    check("accept_seen", 64'(last_acc), 64'd1);
    bus.packet_valid = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          pv;
    logic          cr;
    logic          exp_v;
    logic [FW-1:0] exp_flit;
    logic [CW-1:0] exp_cred;
    logic          exp_rdy;
  } vec_t;

  vec_t tbl[14];

  initial begin
    reset = 1'b1;
    bus.packet_in = '0;
    bus.packet_valid = 1'b0;
    bus.credit_in = 1'b0;

    // Reset then idle
    do_reset(10);
    check("rst_channel", 64'(bus.channel_out), 64'd0);
    check("rst_credits", 64'(credits_available), 64'd5);
    check("rst_ready", 64'(bus.packet_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cerr", 64'(credit_error), 64'd0);
    tick();
    check("idle_ready", 64'(bus.packet_ready), 64'd1);

    // Single packet, full credits: five back-to-back flits
    accept_pkt(mk_pkt(32'hA0000000));
    check("acc_busy", 64'(busy), 64'd1);
    check("acc_no_flit_yet", 64'(bus.channel_out[0]), 64'd0);
    for (int i = 0; i < PF; i++) begin
      tick();
      check("pktA_valid", 64'(bus.channel_out[0]), 64'd1);
      check("pktA_flit", 64'(bus.channel_out[FW:1]), 64'(32'hA0000001 + 32'(i)));
      check("pktA_cred", 64'(credits_available), 64'(4 - i));
    end
    check("pktA_ready_after_last", 64'(bus.packet_ready), 64'd1);
    tick();
    check("pktA_cred_zero", 64'(credits_available), 64'd0);
    check("pktA_valid_drop", 64'(bus.channel_out[0]), 64'd0);

    // Credit starvation: give back only two credits, then trickle them in.
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 32'hA0000005, 3'd1, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'hA0000005, 3'd2, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'hA0000005, 3'd2, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 32'hB0000001, 3'd1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'hB0000002, 3'd0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'hB0000002, 3'd0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'hB0000002, 3'd1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 32'hB0000003, 3'd0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'hB0000003, 3'd1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'hB0000004, 3'd0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 32'hB0000004, 3'd0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 32'hB0000004, 3'd1, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 32'hB0000005, 3'd1, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 32'hB0000005, 3'd1, 1'b1};
    bus.packet_in = mk_pkt(32'hB0000000);
    for (int r = 0; r < 14; r++) begin
      bus.packet_valid = tbl[r].pv;
      bus.credit_in = tbl[r].cr;
      tick();
      check($sformatf("tbl%0d_valid", r), 64'(bus.channel_out[0]), 64'(tbl[r].exp_v));
      check($sformatf("tbl%0d_flit", r), 64'(bus.channel_out[FW:1]), 64'(tbl[r].exp_flit));
      check($sformatf("tbl%0d_cred", r), 64'(credits_available), 64'(tbl[r].exp_cred));
      check($sformatf("tbl%0d_ready", r), 64'(bus.packet_ready), 64'(tbl[r].exp_rdy));
    end
    bus.packet_valid = 1'b0;
    bus.credit_in = 1'b0;

    // Overflow: refill to 5, then one extra credit saturates and sticks.
    for (int i = 0; i < 4; i++) begin
      bus.credit_in = 1'b1;
      tick();
    end
    check("refill_cred", 64'(credits_available), 64'd5);
    check("refill_no_err", 64'(credit_error), 64'd0);
    tick();
    bus.credit_in = 1'b0;
    check("ovf_cred", 64'(credits_available), 64'd5);
    check("ovf_err", 64'(credit_error), 64'd1);
    for (int i = 0; i < 3; i++) tick();
    check("ovf_err_sticky", 64'(credit_error), 64'd1);
    do_reset(1);
    check("ovf_err_cleared", 64'(credit_error), 64'd0);

    // Simultaneous send and credit, plus back-to-back packets.
    bus.packet_in = mk_pkt(32'hC0000000);
    bus.packet_valid = 1'b1;
    tick();
    check("c_accept", 64'(last_acc), 64'd1);
    bus.packet_in = mk_pkt(32'hD0000000);   // held valid; ignored while sending
    bus.credit_in = 1'b1;
    for (int i = 0; i < PF; i++) begin
      tick();
      check("c_flit", 64'(bus.channel_out[FW:1]), 64'(32'hC0000001 + 32'(i)));
      check("c_valid", 64'(bus.channel_out[0]), 64'd1);
      check("c_cred_flat", 64'(credits_available), 64'd5);
    end
    bus.credit_in = 1'b0;
    tick();
    check("d_accept_gap", 64'(last_acc), 64'd1);
    check("d_gap_valid", 64'(bus.channel_out[0]), 64'd0);
    bus.packet_valid = 1'b0;
    bus.credit_in = 1'b1;
    for (int i = 0; i < PF; i++) begin
      tick();
      check("d_flit", 64'(bus.channel_out[FW:1]), 64'(32'hD0000001 + 32'(i)));
      check("d_valid", 64'(bus.channel_out[0]), 64'd1);
      check("d_cred_flat", 64'(credits_available), 64'd5);
    end
    bus.credit_in = 1'b0;
    tick();
    check("cd_no_err", 64'(credit_error), 64'd0);

    // Reset mid-packet: abandon after three flits, next packet starts at flit 0.
    do_reset(1);
    accept_pkt(mk_pkt(32'hE0000000));
    for (int i = 0; i < 3; i++) tick();
    check("e_third_flit", 64'(bus.channel_out[FW:1]), 64'h0000_0000_E000_0003);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_valid", 64'(bus.channel_out[0]), 64'd0);
    check("midrst_cred", 64'(credits_available), 64'd5);
    check("midrst_ready", 64'(bus.packet_ready), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    accept_pkt(mk_pkt(32'hF0000000));
    tick();
    check("f_header_valid", 64'(bus.channel_out[0]), 64'd1);
    check("f_header", 64'(bus.channel_out[FW:1]), 64'h0000_0000_F000_0001);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 2000; c++) begin
      if (!bus.packet_valid && $urandom_range(0, 3) == 0) begin
        logic [PKT_W-1:0] p;
        for (int i = 0; i < PF; i++) p[i*FW +: FW] = $urandom;
        bus.packet_in = p;
        bus.packet_valid = 1'b1;
      end
      bus.credit_in = (m_cred < BD) && ($urandom_range(0, 2) == 0);
      reset = (c == 1000);
      tick();
      if (last_acc) bus.packet_valid = 1'b0;
    end
    reset = 1'b0;
    bus.credit_in = 1'b0;
    bus.packet_valid = 1'b0;
    for (int i = 0; i < 2 * PF; i++) begin
      bus.credit_in = (m_cred < BD);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/packet_flit_transmitter.md
Name: packet_flit_transmitter

Overview:
- Synthesizable credit-based packet injector: the transmitting end of the mesh channel protocol.
- Accepts a whole packet from a local producer (PE or test engine) over a valid/ready handshake.
- Serializes the packet into flits on a network inport channel, consuming one downstream credit per flit.
- Sits between a local packet producer and a node's `CHANNEL_WIDTH` inport / credit outport pair; mirrors what the node-side input buffer expects.

Parameters:
- FLIT_WIDTH, 32, payload bits per flit; channel is FLIT_WIDTH+1 bits (equals `CHANNEL_WIDTH).
- PACKET_FLITS, 5, flits per packet (flit 0 = header, then data flits).
- BUFFER_DEPTH, 5, downstream input-buffer depth; initial and maximum credit count.
- CREDIT_WIDTH, 3, credit counter width; must satisfy 2^CREDIT_WIDTH > BUFFER_DEPTH.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- packet_in  input  PACKET_FLITS*FLIT_WIDTH  packet; flit 0 in MSBs [0:FLIT_WIDTH-1], ascending index order.
- packet_valid  input  1  producer has a packet on packet_in.
- packet_ready  output  1  block can accept a packet this cycle.
- channel_out  output  FLIT_WIDTH+1  bit [0] = flit valid, bits [1:FLIT_WIDTH] = flit.
- credit_in  input  1  one-cycle pulse, one downstream buffer slot freed.
- credits_available  output  CREDIT_WIDTH  current credit count.
- busy  output  1  packet in transmission.
- credit_error  output  1  sticky, credit returned while counter already at BUFFER_DEPTH.

Behaviour:
- Reset values (synchronous, active-high):
  - state = IDLE, channel_out = 0 (valid low, flit zero), credits = BUFFER_DEPTH.
  - flit index = 0, credit_error = 0, busy = 0, packet_ready = 1 on the first cycle after reset deasserts.
- FSM states:
  - IDLE: packet_ready = 1, busy = 0. On packet_valid & packet_ready, latch packet_in into the internal packet register, set flit index = 0, go to SEND.
  - SEND: packet_ready = 0, busy = 1.
    - Each cycle with credits > 0: register flit[index] onto channel_out with valid = 1, decrement credits, increment index.
    - When the flit just sent is index PACKET_FLITS-1: go to IDLE on the same edge.
    - With credits == 0: channel_out valid = 0 (flit field holds last value) and the index holds.
- channel_out is fully registered: no combinational path from credit_in or packet_valid to channel_out.
- Latency:
  - Accept edge k → header valid after edge k+1 if credits > 0.
  - Uninterrupted packet occupies PACKET_FLITS consecutive valid cycles.
  - packet_ready reasserts the cycle after the last flit.
  - Minimum packet-to-packet period = PACKET_FLITS+1 cycles.
- Flits of one packet are never interleaved or reordered (wormhole); gaps appear only from credit starvation.
- Credit arithmetic, per edge:
  - next = credits − sent + credit_in.
  - Send and credit_in in the same cycle → count unchanged.
  - Send with credits == 1 plus credit_in in the same cycle → count stays 1 and the next flit may go.
  - credit_in arriving at credits == 0 enables a send on the following cycle, not the same cycle.
- Overflow: credit_in while credits == BUFFER_DEPTH and no send → count saturates at BUFFER_DEPTH and credit_error sets. credit_error clears only on reset.
- Underflow is impossible by construction; credits never go below 0.
- packet_valid while in SEND is ignored; the producer must hold it until ready.
- Reset mid-packet: the packet is abandoned, channel_out valid drops on the reset edge, credits return to BUFFER_DEPTH. The downstream side is reset concurrently.

Test Plan:
- Reset then idle: hold reset 10 cycles → channel_out = 0, credits_available = 5, packet_ready = 1, busy = 0, credit_error = 0.
- Single packet, full credits: packet_in = flits 0xA0000001..0xA0000005, valid 1 cycle → 5 consecutive valid flits in order starting 1 cycle after accept. Then credits_available = 0 and packet_ready = 1 the next cycle.
- Credit starvation: BUFFER_DEPTH = 2, no credit_in → 2 flits, then valid low. Pulse credit_in once → exactly one more flit one cycle later. Repeat until all 5 are sent, with no duplication or reordering.
- Simultaneous send and credit: credit_in high every cycle during an uninterrupted packet → credits_available stays 5 throughout, and the second packet starts with no gap beyond the idle cycle.
- Overflow: at credits = 5 with no traffic, pulse credit_in → credits_available stays 5 and credit_error = 1 until the next reset.
- Reset mid-packet: assert reset after flit 2 is sent → channel_out valid = 0 on the reset edge, credits = 5. The next packet starts from header flit 0.
